// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises one FRAME_W-bit MOSI frame per ss_n assertion
// and serialises a DATA_W-bit read reply on MISO. One bit per clk cycle.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ss_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic                valid_MISO,
  output logic                sready,
  output logic [DATA_W+1:0]   rx_data,
  output logic                rx_valid,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_valid
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, WAIT_SS
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [FRAME_W-2:0]  sh;
  logic [DATA_W-1:0]   tx_sh;
  logic                rd_addr_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sh           <= '0;
      tx_sh        <= '0;
      rd_addr_flag <= 1'b0;
      MISO         <= 1'b0;
      valid_MISO   <= 1'b0;
      sready       <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n && state != IDLE && state != WAIT_SS) begin
        // Master dropped select mid-transaction: discard partial frame / reply.
        state      <= IDLE;
        sready     <= 1'b1;
        MISO       <= 1'b0;
        valid_MISO <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!ss_n) begin
              state  <= CHK_CMD;
              sready <= 1'b0;
            end
          end
          CHK_CMD: begin
            sh  <= {sh[FRAME_W-3:0], MOSI};
            cnt <= '0;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_flag) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            sh  <= {sh[FRAME_W-3:0], MOSI};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DATA_W)) begin
              rx_data  <= {sh, MOSI};
              rx_valid <= 1'b1;
              cnt      <= '0;
              if (state == READ_DATA) state <= WAIT_TX;
              else                    state <= WAIT_SS;
              if (state == READ_ADD)  rd_addr_flag <= 1'b1;
            end
          end
          WAIT_TX: begin
            if (tx_valid) begin
              // MSB goes out with the latch so MISO is valid on every SEND cycle.
              MISO       <= tx_data[DATA_W-1];
              valid_MISO <= 1'b1;
              tx_sh      <= {tx_data[DATA_W-2:0], 1'b0};
              cnt        <= '0;
              state      <= SEND;
            end
          end
          SEND: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DATA_W-1)) begin
              MISO         <= 1'b0;
              valid_MISO   <= 1'b0;
              rd_addr_flag <= 1'b0;
              state        <= WAIT_SS;
            end else begin
              MISO  <= tx_sh[DATA_W-1];
              tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
          end
          WAIT_SS: begin
            if (ss_n) begin
              state  <= IDLE;
              sready <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            sready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read-addr/read-data, abort, reset-in-SEND,
// and stray tx_valid cases, all against hand-computed values.
module tb_spi_slave_if;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst, ss_n, MOSI, tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              MISO, valid_MISO, sready, rx_valid;
  logic [DATA_W+1:0] rx_data;

  int n_chk = 0;
  int n_err = 0;
  logic early_rv, vm_seen;
  logic [7:0] rep;

  spi_slave_if #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO),
    .valid_MISO(valid_MISO), .sready(sready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Outputs observed here reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ss_n low for t0, then bits 9..0; tv drives tx_valid throughout.
  task automatic send_frame(input logic [9:0] f, input logic tv);
    early_rv = 1'b0;
    vm_seen  = 1'b0;
    tx_valid = tv;
    ss_n     = 1'b0;
    step();
    for (int i = 9; i >= 0; i--) begin
      MOSI = f[i];
      step();
      if (i != 0) early_rv |= rx_valid;
      vm_seen |= valid_MISO;
    end
    tx_valid = 1'b0;
  endtask

  task automatic release_ss();
    ss_n = 1'b1;
    MOSI = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk)
    if (!valid_MISO) chk("miso_zero_when_invalid", {31'd0, MISO}, 32'd0);

  initial begin
    rst = 1'b1; ss_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    rep = 8'hA5;
    step();
    chk("rst_miso", {31'd0, MISO}, 0);
    chk("rst_vmiso", {31'd0, valid_MISO}, 0);
    chk("rst_sready", {31'd0, sready}, 1);
    chk("rst_rx_data", {22'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_flag", {31'd0, dut.rd_addr_flag}, 0);
    rst = 1'b0;

    // 1 + 6: write frame with tx_valid held high in IDLE and WRITE
    tx_valid = 1'b1;
    step();
    chk("t6_idle_vmiso", {31'd0, valid_MISO}, 0);
    send_frame(10'b00_0011_0101, 1'b1);
    chk("t1_early_rv", {31'd0, early_rv}, 0);
    chk("t1_rx_valid", {31'd0, rx_valid}, 1);
    chk("t1_rx_data", {22'd0, rx_data}, 32'h035);
    chk("t1_sready", {31'd0, sready}, 0);
    chk("t6_write_vm", {31'd0, vm_seen}, 0);
    step();
    chk("t1_rv_pulse", {31'd0, rx_valid}, 0);
    chk("t1_wait_ss_vm", {31'd0, valid_MISO}, 0);
    chk("t1_flag", {31'd0, dut.rd_addr_flag}, 0);
    release_ss();
    chk("t1_sready_back", {31'd0, sready}, 1);

    // 2: read-addr then read-data with reply 0xA5; tx_valid during frame ignored
    send_frame(10'b10_1000_0001, 1'b0);
    chk("t2_ra_data", {22'd0, rx_data}, 32'h281);
    step();
    chk("t2_flag_set", {31'd0, dut.rd_addr_flag}, 1);
    release_ss();
    send_frame(10'b11_0000_0000, 1'b1);
    chk("t2_rd_data", {22'd0, rx_data}, 32'h300);
    chk("t6_rd_vm", {31'd0, vm_seen}, 0);
    step(); step();
    chk("t2_wait_tx_vm", {31'd0, valid_MISO}, 0);
    tx_valid = 1'b1; tx_data = rep;
    step();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_vm_%0d", k), {31'd0, valid_MISO}, 1);
      chk($sformatf("t2_miso_%0d", k), {31'd0, MISO}, {31'd0, rep[7-k]});
      step();
    end
    chk("t2_vm_end", {31'd0, valid_MISO}, 0);
    chk("t2_flag_clr", {31'd0, dut.rd_addr_flag}, 0);
    chk("t2_sready_wss", {31'd0, sready}, 0);
    release_ss();
    chk("t2_sready", {31'd0, sready}, 1);

    // 3: read-data cmd with flag=0 is routed as READ_ADD
    do_reset();
    send_frame(10'b11_0101_0101, 1'b0);
    chk("t3_rx_valid", {31'd0, rx_valid}, 1);
    chk("t3_rx_data", {22'd0, rx_data}, 32'h355);
    tx_valid = 1'b1; tx_data = 8'hFF;
    step(); step(); step();
    chk("t3_no_send", {31'd0, valid_MISO}, 0);
    chk("t3_flag", {31'd0, dut.rd_addr_flag}, 1);
    tx_valid = 1'b0;
    release_ss();

    // 4: abort after 5 bits of a write frame, then a full frame
    do_reset();
    ss_n = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      MOSI = i[0];
      step();
    end
    ss_n = 1'b1;
    step();
    chk("t4_abort_rv", {31'd0, rx_valid}, 0);
    step();
    chk("t4_sready", {31'd0, sready}, 1);
    chk("t4_rx_hold", {22'd0, rx_data}, 0);
    send_frame(10'b01_0010_1100, 1'b0);
    chk("t4_rx_valid", {31'd0, rx_valid}, 1);
    chk("t4_rx_data", {22'd0, rx_data}, 32'h12C);
    release_ss();

    // 5: reset during SEND after bit 3
    do_reset();
    send_frame(10'b10_0000_0001, 1'b0);
    release_ss();
    send_frame(10'b11_1111_1111, 1'b0);
    tx_valid = 1'b1; tx_data = 8'h3C;
    step();
    tx_valid = 1'b0;
    rep = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_miso_%0d", k), {31'd0, MISO}, {31'd0, rep[7-k]});
      if (k < 3) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_miso", {31'd0, MISO}, 0);
    chk("t5_vmiso", {31'd0, valid_MISO}, 0);
    chk("t5_sready", {31'd0, sready}, 1);
    chk("t5_flag", {31'd0, dut.rd_addr_flag}, 0);
    release_ss();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
